// File: rtl/sram1024x18_fifo_pkg.sv
// Shared constants and types for the sram1024x18 FIFO controller.
package sram1024x18_fifo_pkg;
   localparam int DEPTH   = 1024;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 18;
   localparam int LEVEL_W = 11;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [LEVEL_W-1:0] level_t;
endpackage

// File: rtl/sram1024x18_fifo_obuf.sv
// Two-entry first-word-fall-through buffer that absorbs the SRAM read latency.
module sram1024x18_fifo_obuf
   import sram1024x18_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       flush,
   input  logic       rd_pend,
   input  data_t      ram_rdata_b,
   output logic       m_valid,
   input  logic       m_ready,
   output data_t      m_data,
   output logic [1:0] ob_cnt
);
   data_t ent0;
   data_t ent1;
   logic  pop;

   assign m_valid = (ob_cnt != 2'd0);
   assign m_data  = ent0;
   assign pop     = m_valid & m_ready;

   // The read scheduler guarantees a free slot whenever rd_pend is set,
   // so capture lands at the tail position left after this cycle's pop.
   always_ff @(posedge clk) begin
      if (flush) begin
         ob_cnt <= 2'd0;
      end else begin
         unique case ({pop, rd_pend})
            2'b10: begin
               ent0   <= ent1;
               ob_cnt <= ob_cnt - 2'd1;
            end
            2'b01: begin
               if (ob_cnt == 2'd0) ent0 <= ram_rdata_b;
               else                ent1 <= ram_rdata_b;
               ob_cnt <= ob_cnt + 2'd1;
            end
            2'b11: begin
               if (ob_cnt == 2'd2) begin
                  ent0 <= ent1;
                  ent1 <= ram_rdata_b;
               end else begin
                  ent0 <= ram_rdata_b;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/sram1024x18_fifo_ctl.sv
// Ready/valid FIFO controller driving one sram1024x18 (port A write, port B read).
// Optional almost_full/almost_empty outputs under SRAM1024X18_FIFO_CTL_ALMOST_FLAGS_EN.
module sram1024x18_fifo_ctl
   import sram1024x18_fifo_pkg::*;
#(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 10
`ifdef SRAM1024X18_FIFO_CTL_ALMOST_FLAGS_EN
   ,parameter int AF_LEVEL = 1020,
   parameter int AE_LEVEL = 4
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [ADDR_W:0]   level,
`ifdef SRAM1024X18_FIFO_CTL_ALMOST_FLAGS_EN
   output logic              almost_full,
   output logic              almost_empty,
`endif
   output logic              ram_cen_a,
   output logic              ram_wen_a,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_wmsk_a,
   output logic [DATA_W-1:0] ram_wdata_a,
   output logic              ram_cen_b,
   output logic              ram_wen_b,
   output logic [ADDR_W-1:0] ram_addr_b,
   input  logic [DATA_W-1:0] ram_rdata_b
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(2**ADDR_W);

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   mem_cnt;
   logic [ADDR_W:0]   mem_cnt_nxt;
   logic              rd_pend;
   logic [1:0]        ob_cnt;
   logic [1:0]        occ;
   logic              flush;
   logic              push;
   logic              pop;
   logic              issue;

   assign flush   = rst | clr;
   assign s_ready = !flush && (mem_cnt != FULL_CNT);
   assign push    = s_valid & s_ready;
   assign pop     = m_valid & m_ready;
   assign occ     = ob_cnt + {1'b0, rd_pend};
   // A pop this cycle frees the slot a read issued now will land in.
   assign issue   = !flush && (mem_cnt != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

   assign ram_cen_a   = !push;
   assign ram_wen_a   = !push;
   assign ram_addr_a  = wptr;
   assign ram_wdata_a = s_data;
   assign ram_wmsk_a  = '0;
   assign ram_cen_b   = !issue;
   assign ram_wen_b   = 1'b1;
   assign ram_addr_b  = rptr;

   assign mem_cnt_nxt = mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
   assign level       = mem_cnt + (ADDR_W+1)'(rd_pend) + (ADDR_W+1)'(ob_cnt);

   always_ff @(posedge clk) begin
      if (flush) begin
         wptr    <= '0;
         rptr    <= '0;
         mem_cnt <= '0;
         rd_pend <= 1'b0;
      end else begin
         if (push)  wptr <= wptr + ADDR_W'(1);
         if (issue) rptr <= rptr + ADDR_W'(1);
         mem_cnt <= mem_cnt_nxt;
         rd_pend <= issue;
      end
   end

   sram1024x18_fifo_obuf u_obuf (
      .clk         (clk),
      .flush       (flush),
      .rd_pend     (rd_pend),
      .ram_rdata_b (ram_rdata_b),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .ob_cnt      (ob_cnt)
   );

`ifdef SRAM1024X18_FIFO_CTL_ALMOST_FLAGS_EN
   logic [1:0]      ob_cnt_nxt;
   logic [ADDR_W:0] level_nxt;

   assign ob_cnt_nxt = ob_cnt + {1'b0, rd_pend} - {1'b0, pop};
   assign level_nxt  = flush ? '0
                     : mem_cnt_nxt + (ADDR_W+1)'(issue) + (ADDR_W+1)'(ob_cnt_nxt);

   always_ff @(posedge clk) begin
      almost_full  <= (level_nxt >= (ADDR_W+1)'(AF_LEVEL));
      almost_empty <= (level_nxt <= (ADDR_W+1)'(AE_LEVEL));
   end
`endif

   // Reads only target stored words and writes only happen below full, so
   // both ports can never address the same word in one cycle.
   a_no_collision: assert property (@(posedge clk) disable iff (rst)
      !(!ram_cen_a && !ram_cen_b && (ram_addr_a == ram_addr_b)));
endmodule
